// File: rtl/projectile_ctrl.sv
// rtl/projectile_ctrl.sv - per-frame projectile launch, flight, bounce and target-hit FSM
// Position, exist and direction feed the sprite renderer directly, so every output is a register.
module projectile_ctrl #(
  parameter logic [7:0] FIRE_KEY   = 8'h2C,
  parameter logic [9:0] SPAWN_X    = 10'd90,
  parameter logic [9:0] SPAWN_Y    = 10'd52,
  parameter logic [9:0] MAX_FLIGHT = 10'd600,
  parameter logic [4:0] COOLDOWN   = 5'd16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [3:0] turret_angle,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_exist,
  output logic       bullet_dir,
  output logic       hit_pulse,
  output logic [7:0] score,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_COOL   = 2'd2
  } state_t;

  state_t             cur;
  logic signed [3:0]  vx, vy, tab_vx, tab_vy;
  logic        [9:0]  flight_cnt;
  logic        [4:0]  cool_cnt;
  logic        [7:0]  prev_key;
  logic               fire, hit, left_exit;
  logic signed [10:0] nx, ny;

  always_comb begin
    tab_vx = 4'sd4;
    tab_vy = 4'sd0;
    case (turret_angle)
      4'd0: begin tab_vx = 4'sd0; tab_vy = -4'sd4; end
      4'd1: begin tab_vx = 4'sd2; tab_vy = -4'sd3; end
      4'd2: begin tab_vx = 4'sd3; tab_vy = -4'sd3; end
      4'd3: begin tab_vx = 4'sd3; tab_vy = -4'sd2; end
      4'd5: begin tab_vx = 4'sd3; tab_vy = 4'sd2;  end
      4'd6: begin tab_vx = 4'sd3; tab_vy = 4'sd3;  end
      4'd7: begin tab_vx = 4'sd2; tab_vy = 4'sd3;  end
      4'd8: begin tab_vx = 4'sd0; tab_vy = 4'sd4;  end
      default: begin tab_vx = 4'sd4; tab_vy = 4'sd0; end
    endcase
  end

  assign fire = (keycode == FIRE_KEY) && (prev_key != FIRE_KEY);
  assign nx   = $signed({1'b0, bullet_x}) + $signed({{7{vx[3]}}, vx});
  assign ny   = $signed({1'b0, bullet_y}) + $signed({{7{vy[3]}}, vy});
  // 40x10 box against target [590,640)x[380,480), on the pre-move position
  assign hit  = (bullet_x > 10'd550) && (bullet_x < 10'd640) &&
                (bullet_y > 10'd370) && (bullet_y < 10'd480);
  assign left_exit = vx[3] && (nx <= 11'sd10);
  assign state = cur;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cur          <= ST_IDLE;
      bullet_x     <= SPAWN_X;
      bullet_y     <= SPAWN_Y;
      bullet_exist <= 1'b0;
      bullet_dir   <= 1'b0;
      hit_pulse    <= 1'b0;
      score        <= 8'd0;
      vx           <= 4'sd0;
      vy           <= 4'sd0;
      flight_cnt   <= 10'd0;
      cool_cnt     <= 5'd0;
      prev_key     <= 8'd0;
    end else begin
      prev_key  <= keycode;
      hit_pulse <= 1'b0;
      case (cur)
        ST_IDLE: begin
          if (fire) begin
            vx           <= tab_vx;
            vy           <= tab_vy;
            bullet_x     <= SPAWN_X;
            bullet_y     <= SPAWN_Y;
            bullet_exist <= 1'b1;
            bullet_dir   <= 1'b0;
            flight_cnt   <= 10'd0;
            cur          <= ST_FLIGHT;
          end
        end
        ST_FLIGHT: begin
          if (hit) begin
            hit_pulse    <= 1'b1;
            score        <= (score == 8'hFF) ? score : score + 8'd1;
            bullet_exist <= 1'b0;
            cool_cnt     <= 5'd0;
            cur          <= ST_COOL;
          end else if (flight_cnt == MAX_FLIGHT - 10'd1 || left_exit) begin
            bullet_exist <= 1'b0;
            cool_cnt     <= 5'd0;
            cur          <= ST_COOL;
          end else begin
            if (ny < 11'sd0) begin
              bullet_y <= 10'd0;
              vy       <= -vy;
            end else if (ny > 11'sd469) begin
              bullet_y <= 10'd469;
              vy       <= -vy;
            end else begin
              bullet_y <= ny[9:0];
            end
            if (nx >= 11'sd599) begin
              bullet_x   <= 10'd599;
              vx         <= -vx;
              bullet_dir <= 1'b1;
            end else begin
              bullet_x <= nx[9:0];
            end
            flight_cnt <= flight_cnt + 10'd1;
          end
        end
        ST_COOL: begin
          if (cool_cnt == COOLDOWN - 5'd1) begin
            cool_cnt <= 5'd0;
            cur      <= ST_IDLE;
          end else begin
            cool_cnt <= cool_cnt + 5'd1;
          end
        end
        default: cur <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_projectile_ctrl.sv
// tb/tb_projectile_ctrl.sv - directed and randomized bench for projectile_ctrl
// Reference model tracks the projectile as plain integers stepped once per frame.
module tb_projectile_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [3:0] turret_angle;
  logic [9:0] bullet_x, bullet_y;
  logic       bullet_exist, bullet_dir, hit_pulse;
  logic [7:0] score;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  int vx_tab [9] = '{0, 2, 3, 3, 4, 3, 3, 2, 0};
  int vy_tab [9] = '{-4, -3, -3, -2, 0, 2, 3, 3, 4};

  int m_state, m_x, m_y, m_vx, m_vy, m_exist, m_dir, m_hit, m_score;
  int m_age, m_cool_left, m_prev;

  projectile_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .turret_angle (turret_angle),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_exist (bullet_exist),
    .bullet_dir   (bullet_dir),
    .hit_pulse    (hit_pulse),
    .score        (score),
    .state        (state)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic model_reset();
    m_state = 0; m_x = 90; m_y = 52; m_vx = 0; m_vy = 0;
    m_exist = 0; m_dir = 0; m_hit = 0; m_score = 0;
    m_age = 0; m_cool_left = 0; m_prev = 0;
  endtask

  task automatic model_edge(input int key, input int ang);
    int prev, a, nx, ny;
    prev   = m_prev;
    m_prev = key;
    m_hit  = 0;
    if (m_state == 0) begin
      if (key == 8'h2C && prev != 8'h2C) begin
        a = (ang > 8) ? 4 : ang;
        m_vx = vx_tab[a]; m_vy = vy_tab[a];
        m_x = 90; m_y = 52; m_exist = 1; m_dir = 0; m_age = 0;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (m_x + 40 > 590 && m_x < 640 && m_y + 10 > 380 && m_y < 480) begin
        m_hit = 1;
        m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
        m_exist = 0; m_state = 2; m_cool_left = 16;
      end else if (m_age == 599 || (m_vx < 0 && m_x + m_vx <= 10)) begin
        m_exist = 0; m_state = 2; m_cool_left = 16;
      end else begin
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        if (ny < 0) begin m_y = 0; m_vy = -m_vy; end
        else if (ny + 10 > 479) begin m_y = 469; m_vy = -m_vy; end
        else m_y = ny;
        if (nx + 40 >= 639) begin m_x = 599; m_vx = -m_vx; m_dir = 1; end
        else m_x = nx;
        m_age++;
      end
    end else begin
      m_cool_left--;
      if (m_cool_left == 0) m_state = 0;
    end
  endtask

  function automatic logic [32:0] model_vec();
    return {10'(m_x), 10'(m_y), 1'(m_exist), 1'(m_dir), 1'(m_hit), 8'(m_score), 2'(m_state)};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {bullet_x, bullet_y, bullet_exist, bullet_dir, hit_pulse, score, state};
  endfunction

  task automatic tick(input logic [7:0] key, input logic [3:0] ang);
    keycode = key;
    turret_angle = ang;
    model_edge(int'(key), int'(ang));
    @(posedge frame_clk);
    #1;
  endtask

  task automatic drain(input int bound, output bit ok);
    int n = 0;
    while (state != 2'd0 && n < bound) begin
      tick(8'h00, 4'd0);
      n++;
    end
    ok = (state == 2'd0);
  endtask

  task automatic test_reset();
    Reset = 1'b1; keycode = 8'h00; turret_angle = 4'd0;
    model_reset();
    #2;
    n_tests++;
    if (dut_vec() !== {10'd90, 10'd52, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), {10'd90, 10'd52, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0});
    end
    @(posedge frame_clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_angle4();
    bit seen599 = 0;
    int n = 0, score0;
    bit ok;
    score0 = m_score;
    tick(8'h2C, 4'd4);
    n_tests++;
    if ({bullet_x, bullet_y, bullet_exist, state} !== {10'd90, 10'd52, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL a4_launch: got x=%0d y=%0d e=%0d s=%0d expected 90 52 1 1", bullet_x, bullet_y, bullet_exist, state);
    end
    while (state == 2'd1 && n < 800) begin
      tick(8'h00, 4'd4);
      n++;
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL a4_flight frame %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
      if (bullet_x == 10'd599 && !seen599) begin
        seen599 = 1;
        n_tests++;
        if (bullet_dir !== 1'b1) begin
          n_fail++;
          $display("FAIL a4_dir_at_599: got %0d expected 1", bullet_dir);
        end
      end
    end
    n_tests++;
    if (!seen599 || state !== 2'd2 || bullet_exist !== 1'b0 || score !== 8'(score0)) begin
      n_fail++;
      $display("FAIL a4_left_exit: seen599=%0d state=%0d exist=%0d score=%0d expected 1 2 0 %0d",
               seen599, state, bullet_exist, score, score0);
    end
    for (int i = 0; i < 15; i++) tick(8'h00, 4'd0);
    n_tests++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL cooldown_15: got state %0d expected 2", state);
    end
    tick(8'h00, 4'd0);
    n_tests++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL cooldown_16: got state %0d expected 0", state);
    end
    drain(40, ok);
  endtask

  task automatic test_angle0();
    int flight = 0, miny = 1000;
    bit ok;
    tick(8'h2C, 4'd0);
    while (state == 2'd1 && flight < 700) begin
      flight++;
      if (bullet_y < miny) miny = bullet_y;
      tick(8'h00, 4'd0);
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL a0_flight frame %0d: got %h expected %h", flight, dut_vec(), model_vec());
      end
    end
    n_tests++;
    if (flight != 600 || miny != 0 || state !== 2'd2 || bullet_x !== 10'd90) begin
      n_fail++;
      $display("FAIL a0_timeout: got frames=%0d miny=%0d state=%0d x=%0d expected 600 0 2 90",
               flight, miny, state, bullet_x);
    end
    drain(40, ok);
  endtask

  task automatic test_hit();
    int n, score0;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      score0 = score;
      tick(8'h2C, 4'd6);
      n = 0;
      while (state == 2'd1 && n < 700) begin
        tick(8'h00, 4'd6);
        n++;
        n_tests++;
        if (dut_vec() !== model_vec()) begin
          n_fail++;
          $display("FAIL hit_flight frame %0d: got %h expected %h", n, dut_vec(), model_vec());
        end
        if (n == 110) begin
          n_tests++;
          if ({bullet_x, bullet_y} !== {10'd420, 10'd382}) begin
            n_fail++;
            $display("FAIL hit_frame110: got (%0d,%0d) expected (420,382)", bullet_x, bullet_y);
          end
        end
      end
      n_tests++;
      if ({hit_pulse, bullet_exist, bullet_x, bullet_y, state} !== {1'b1, 1'b0, 10'd552, 10'd427, 2'd2} ||
          score !== 8'(score0 + 1)) begin
        n_fail++;
        $display("FAIL hit_event: got hp=%0d e=%0d (%0d,%0d) s=%0d score=%0d expected 1 0 (552,427) 2 %0d",
                 hit_pulse, bullet_exist, bullet_x, bullet_y, state, score, score0 + 1);
      end
      tick(8'h00, 4'd0);
      n_tests++;
      if (hit_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL hit_pulse_width: got %0d expected 0", hit_pulse);
      end
      drain(40, ok);
    end
  endtask

  task automatic test_reset_mid_flight();
    tick(8'h2C, 4'd3);
    for (int i = 0; i < 20; i++) tick(8'h00, 4'd3);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec() !== {10'd90, 10'd52, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_flight: got %h expected %h", dut_vec(), {10'd90, 10'd52, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0});
    end
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_hold_key();
    int launches = 0;
    logic [1:0] last;
    bit ok;
    last = state;
    for (int i = 0; i < 200; i++) begin
      tick(8'h2C, 4'd5);
      if (last == 2'd0 && state == 2'd1) launches++;
      last = state;
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL hold_frame %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    n_tests++;
    if (launches != 1 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL hold_single_launch: got launches=%0d state=%0d expected 1 0", launches, state);
    end
    tick(8'h00, 4'd5);
    tick(8'h2C, 4'd5);
    n_tests++;
    if (state !== 2'd1 || bullet_exist !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_relaunch: got state=%0d exist=%0d expected 1 1", state, bullet_exist);
    end
    drain(700, ok);
  endtask

  task automatic test_angle_latch();
    bit ok;
    tick(8'h2C, 4'd2);
    for (int i = 0; i < 5; i++) tick(8'h00, 4'd8);
    n_tests++;
    if ({bullet_x, bullet_y} !== {10'd105, 10'd37}) begin
      n_fail++;
      $display("FAIL angle_latch: got (%0d,%0d) expected (105,37)", bullet_x, bullet_y);
    end
    drain(700, ok);
    tick(8'h2C, 4'd9);
    for (int i = 0; i < 5; i++) tick(8'h00, 4'd9);
    n_tests++;
    if ({bullet_x, bullet_y} !== {10'd110, 10'd52}) begin
      n_fail++;
      $display("FAIL angle_oob: got (%0d,%0d) expected (110,52)", bullet_x, bullet_y);
    end
    drain(700, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout: got state %0d expected 0", state);
    end
  endtask

  task automatic test_random();
    logic [7:0] k;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        #1; Reset = 1'b1; #1; Reset = 1'b0;
        model_reset();
      end
      case ($urandom_range(0, 3))
        0: k = 8'h2C;
        1: k = 8'(32'($urandom_range(1, 255)));
        default: k = 8'h00;
      endcase
      tick(k, 4'($urandom_range(0, 15)));
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random frame %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_angle4();
    test_angle0();
    test_hit();
    test_reset_mid_flight();
    test_hold_key();
    test_angle_latch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
